// File: rtl/boron_perm_pkg.sv
// -----------------------------------------------------------------------------
// boron_perm_pkg
//
// Shared definitions for the BORON permutation-layer blocks.
//   BANK_W     : width of one shuffle bank (bits)
//   bs_state_t : control states of the iterative block shuffle
//   DIR_ENC    : direction flag value selecting the encrypt (rotate-left) path
//   DIR_DEC    : direction flag value selecting the decrypt (rotate-right) path
// -----------------------------------------------------------------------------
package boron_perm_pkg;

  localparam int BANK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a word, in_ready high
    RUN  = 2'd1,  // applying the bank shuffle once per clock
    DONE = 2'd2   // result presented, waiting for the consumer
  } bs_state_t;

  localparam logic DIR_ENC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

endpackage : boron_perm_pkg

// File: rtl/block_shuffle_bank_rot.sv
// -----------------------------------------------------------------------------
// block_shuffle_bank_rot
//
// Purely combinational rotation of a single 16-bit bank. One instance exists
// per bank of the shuffle state, so no bit ever crosses a bank boundary.
//
// Parameters:
//   ROT  : rotation amount in bits, legal range 1..15
// Ports:
//   dir  in  1       DIR_ENC rotates left by ROT, DIR_DEC rotates right by ROT
//   din  in  BANK_W  bank value before the shuffle step
//   dout out BANK_W  bank value after the shuffle step
// -----------------------------------------------------------------------------
module block_shuffle_bank_rot
  import boron_perm_pkg::*;
#(
  parameter int ROT = 4
) (
  input  logic              dir,
  input  logic [BANK_W-1:0] din,
  output logic [BANK_W-1:0] dout
);

  logic [BANK_W-1:0] rot_left;
  logic [BANK_W-1:0] rot_right;

  // ROT is a constant, so both rotations reduce to wiring; only the direction
  // mux costs logic.
  assign rot_left  = (din << ROT) | (din >> (BANK_W - ROT));
  assign rot_right = (din >> ROT) | (din << (BANK_W - ROT));

  assign dout = (dir == DIR_DEC) ? rot_right : rot_left;

endmodule : block_shuffle_bank_rot

// File: rtl/block_shuffle_iter.sv
// -----------------------------------------------------------------------------
// block_shuffle_iter
//
// Iterative bank-wise block shuffle. A word accepted on the input handshake is
// rotated bank-by-bank (left for encrypt, right for decrypt) once per clock,
// in_iter times, then presented on the output handshake until consumed.
// Latency from the accepting edge to out_valid is in_iter+1 cycles; a count of
// zero passes the word through unchanged after one cycle.
//
// Parameters:
//   NBANK  : number of 16-bit banks, state width W = 16*NBANK
//   ROT    : per-bank rotation amount in bits (1..15)
//   ITER_W : width of the iteration count
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       input word offered
//   in_ready   out  1       block can accept a word (IDLE only)
//   in_data    in   W       state to shuffle
//   in_dec     in   1       1 = decrypt direction, 0 = encrypt direction
//   in_iter    in   ITER_W  number of shuffle applications
//   out_valid  out  1       result available (DONE)
//   out_ready  in   1       consumer accepts result
//   out_data   out  W       shuffled state
//   out_dec    out  1       direction flag echoed with the result
//   busy       out  1       high in RUN or DONE
// -----------------------------------------------------------------------------
module block_shuffle_iter
  import boron_perm_pkg::*;
#(
  parameter int NBANK  = 4,
  parameter int ROT    = 4,
  parameter int ITER_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BANK_W*NBANK-1:0] in_data,
  input  logic                    in_dec,
  input  logic [ITER_W-1:0]       in_iter,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BANK_W*NBANK-1:0] out_data,
  output logic                    out_dec,
  output logic                    busy
);

  localparam int W = BANK_W * NBANK;

  localparam logic [ITER_W-1:0] CNT_ZERO = '0;
  localparam logic [ITER_W-1:0] CNT_ONE  = ITER_W'(1);

  bs_state_t         state_q;
  bs_state_t         state_d;

  logic [W-1:0]      data_q;
  logic              dec_q;
  logic [ITER_W-1:0] cnt_q;

  logic [W-1:0]      shuffled;
  logic              accept;
  logic              last_step;

  // ---------------------------------------------------------------------------
  // Bank shuffle: one independent rotator per bank, all driven by the latched
  // direction so a transaction never changes direction part-way through.
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    block_shuffle_bank_rot #(
      .ROT (ROT)
    ) u_bank_rot (
      .dir  (dec_q),
      .din  (data_q[b*BANK_W +: BANK_W]),
      .dout (shuffled[b*BANK_W +: BANK_W])
    );
  end

  assign accept    = in_valid && (state_q == IDLE);
  // A count of zero in RUN cannot arise from a legal acceptance, but treating
  // it as the last step keeps the FSM from spinning if it ever does.
  assign last_step = (cnt_q == CNT_ONE) || (cnt_q == CNT_ZERO);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (in_iter == CNT_ZERO) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Return to IDLE only; in_ready rises the cycle after the handshake.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: handshake and status flags are pure functions of the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: state word, direction flag and iteration counter.
  // Inputs are sampled only on the accepting edge. In DONE nothing is written,
  // which is what holds out_data/out_dec stable under backpressure.
  // ---------------------------------------------------------------------------
  // NOTE: the state word is a plain register, not a memory, and its reset
  // value is visible on out_data, so it is reset along with the control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dec_q  <= DIR_ENC;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            data_q <= in_data;
            dec_q  <= in_dec;
            cnt_q  <= in_iter;
          end
        end
        RUN: begin
          data_q <= shuffled;
          // Saturate at zero; the counter is never decremented below it.
          if (cnt_q != CNT_ZERO) begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          // DONE: hold everything until the result is consumed.
        end
      endcase
    end
  end

  assign out_data = data_q;
  assign out_dec  = dec_q;

endmodule : block_shuffle_iter

// File: tb/tb_block_shuffle_iter.sv
// -----------------------------------------------------------------------------
// tb_block_shuffle_iter
//
// Self-checking bench for block_shuffle_iter (NBANK=4, ROT=4, ITER_W=4).
// Directed vector table, hand-written backpressure and mid-run reset
// sequences, randomized transactions against a rotation-amount model, and
// encrypt/decrypt round-trip identity checks.
// -----------------------------------------------------------------------------
module tb_block_shuffle_iter;

  localparam int NBANK  = 4;
  localparam int ROT    = 4;
  localparam int ITER_W = 4;
  localparam int W      = 16 * NBANK;
  localparam int BUDGET = 40;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              in_dec;
  logic [ITER_W-1:0] in_iter;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_dec;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  block_shuffle_iter #(
    .NBANK  (NBANK),
    .ROT    (ROT),
    .ITER_W (ITER_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dec    (in_dec),
    .in_iter   (in_iter),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dec   (out_dec),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] data;
    logic         dec;
    logic [3:0]   iter;
    logic [W-1:0] exp_data;
    int           exp_lat;
  } vec_t;

  vec_t vecs[6];

  // Reference: n applications of a ROT-bit bank rotation is a single rotation
  // by n*ROT mod 16; decrypt is the complementary left rotation.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dec, input int n);
    logic [W-1:0] r;
    logic [15:0]  v;
    int           amt;
    amt = (n * ROT) % 16;
    if (dec) amt = (16 - amt) % 16;
    r = '0;
    for (int b = 0; b < NBANK; b++) begin
      v = d[16*b +: 16];
      r[16*b +: 16] = (amt == 0) ? v : ((v << amt) | (v >> (16 - amt)));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one word; returns #1 after the accepting edge with the inputs scrambled
  // so that any sampling outside the accepting edge shows up as wrong data.
  task automatic accept(input logic [W-1:0] d, input logic dec, input logic [3:0] it);
    int waitc = 0;
    while (!in_ready && waitc < BUDGET) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("in_ready_before_accept", W'(in_ready), W'(1));
    in_valid = 1'b1;
    in_data  = d;
    in_dec   = dec;
    in_iter  = it;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_dec   = ~dec;
    in_iter  = ITER_W'($urandom);
  endtask

  // Counts edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < BUDGET) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy || in_ready) busy_ok = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] d, input logic dec, input logic [3:0] it,
                     output logic [W-1:0] res, output logic rdec, output int lat,
                     output bit busy_ok);
    accept(d, dec, it);
    wait_done(lat, busy_ok);
    res  = out_data;
    rdec = out_dec;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] hold;
    logic [W-1:0] d;
    logic         rdec;
    logic         dec;
    logic [3:0]   it;
    int           lat;
    bit           bok;

    vecs[0] = '{"enc_iter1",  64'h0123_4567_89AB_CDEF, 1'b0, 4'd1,  64'h1230_5674_9AB8_DEFC, 2};
    vecs[1] = '{"dec_iter1",  64'h0123_4567_89AB_CDEF, 1'b1, 4'd1,  64'h3012_7456_B89A_FCDE, 2};
    vecs[2] = '{"iter0",      64'hDEAD_BEEF_CAFE_F00D, 1'b0, 4'd0,  64'hDEAD_BEEF_CAFE_F00D, 1};
    vecs[3] = '{"enc_iter4",  64'h0F1E_2D3C_4B5A_6978, 1'b0, 4'd4,  64'h0F1E_2D3C_4B5A_6978, 5};
    vecs[4] = '{"dec_iter4",  64'hA5A5_1234_FFFF_0001, 1'b1, 4'd4,  64'hA5A5_1234_FFFF_0001, 5};
    vecs[5] = '{"enc_iter15", 64'h8000_0001_7FFE_C3C3, 1'b0, 4'd15, 64'h0800_1000_E7FF_3C3C, 16};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dec    = 1'b0;
    in_iter   = '0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy",      W'(busy),      W'(0));
    check("rst_out_data",  out_data,      '0);
    check("rst_out_dec",   W'(out_dec),   W'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run(vecs[i].data, vecs[i].dec, vecs[i].iter, res, rdec, lat, bok);
      check({vecs[i].name, "_data"}, res, vecs[i].exp_data);
      check({vecs[i].name, "_lat"},  W'(lat), W'(vecs[i].exp_lat));
      check({vecs[i].name, "_dec"},  W'(rdec), W'(vecs[i].dec));
      check({vecs[i].name, "_busy"}, W'(bok), W'(1));
    end

    // Backpressure: hold the result for 10 cycles with a competing offer.
    out_ready = 1'b0;
    accept(64'h1111_2222_3333_4444, 1'b0, 4'd2);
    wait_done(lat, bok);
    check("bp_lat",  W'(lat), W'(3));
    check("bp_data", out_data, model(64'h1111_2222_3333_4444, 1'b0, 2));
    hold = model(64'h1111_2222_3333_4444, 1'b0, 2);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      in_dec   = 1'b1;
      in_iter  = ITER_W'($urandom);
      @(posedge clk); #1;
      check("bp_hold_data",  out_data,      hold);
      check("bp_hold_ready", W'(in_ready),  W'(0));
      check("bp_hold_valid", W'(out_valid), W'(1));
      check("bp_hold_dec",   W'(out_dec),   W'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", W'(in_ready),  W'(1));
    check("bp_release_valid", W'(out_valid), W'(0));
    check("bp_release_busy",  W'(busy),      W'(0));

    // Reset two cycles into a 15-iteration run.
    accept(64'h5555_AAAA_1357_2468, 1'b1, 4'd15);
    @(posedge clk); #1;
    check("mid_run_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", W'(out_valid), W'(0));
    check("mrst_busy",      W'(busy),      W'(0));
    check("mrst_in_ready",  W'(in_ready),  W'(1));
    check("mrst_out_data",  out_data,      '0);
    #2 rst_n = 1'b1;
    d = 64'h0123_4567_89AB_CDEF;
    run(d, 1'b1, 4'd3, res, rdec, lat, bok);
    check("post_rst_data", res, model(d, 1'b1, 3));
    check("post_rst_lat",  W'(lat), W'(4));
    check("post_rst_dec",  W'(rdec), W'(1));

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      d   = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      it  = 4'($urandom_range(0, 15));
      run(d, dec, it, res, rdec, lat, bok);
      check("rand_data", res, model(d, dec, int'(it)));
      check("rand_lat",  W'(lat), W'(int'(it) + 1));
      check("rand_dec",  W'(rdec), W'(dec));
    end

    // Round trip: encrypt then decrypt with the same count.
    for (int n = 0; n < 6; n++) begin
      logic [W-1:0] mid;
      d  = {$urandom, $urandom};
      it = 4'($urandom_range(1, 15));
      run(d, 1'b0, it, mid, rdec, lat, bok);
      run(mid, 1'b1, it, res, rdec, lat, bok);
      check("roundtrip", res, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_block_shuffle_iter

// File: doc/block_shuffle_iter.md
Name: block_shuffle_iter

Overview:
- Parametrised, sequential successor of the decryption-only block shuffle.
- Applies the bank-wise block shuffle (encrypt or decrypt direction, chosen per transaction) to an NBANK x 16-bit state, iterating 0..MAX_ITER times, one application per clock.
- Sits between the round-key XOR and the round permutation in the iterative BORON datapath.
- Valid/ready on both sides, so it can stall against the round controller.

Parameters:
- NBANK, 4, number of 16-bit banks; state width W = 16*NBANK.
- ROT, 4, bank rotation amount in bits (1..15). Encrypt rotates each bank left by ROT; decrypt rotates each bank right by ROT.
- ITER_W, 4, width of the iteration-count field; maximum count is 2^ITER_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word offered
- in_ready  out  1  block can accept a word
- in_data  in  W  state to shuffle
- in_dec  in  1  1 = decrypt direction, 0 = encrypt direction
- in_iter  in  ITER_W  number of shuffle applications
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  W  shuffled state
- out_dec  out  1  direction flag echoed with the result
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; in_ready=1; out_valid=0; out_data=0; out_dec=0; busy=0.
  - Iteration counter = 0.
- Bank function, bank b = bits [16b+15:16b]:
  - Encrypt: bank rotated left by ROT.
  - Decrypt: bank rotated right by ROT.
  - Banks are independent; no bits cross bank boundaries.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into the state register, and latch in_dec and in_iter into the counter.
  - in_iter==0: go to DONE with the data unchanged (latency 1 cycle).
  - Otherwise go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: state <= shuffle(state, dec); counter <= counter-1.
  - When the counter reaches 1, the final application occurs and the FSM goes to DONE.
  - Total latency from acceptance to out_valid = in_iter+1 cycles.
- DONE:
  - out_valid=1; out_data and out_dec are held stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE. in_ready rises on the next cycle; there is no same-cycle re-accept.
- Backpressure:
  - While out_valid=1 and out_ready=0, data, flag and counter are frozen.
  - in_ready stays 0 outside IDLE.
- Counter:
  - Unsigned, ITER_W wide, never decremented below 0.
  - Maximum in_iter = 2^ITER_W-1, with latency 2^ITER_W cycles.
- Inputs in_data, in_dec and in_iter are sampled only on the accepting edge; changes while busy are ignored.
- Reset mid-RUN or mid-DONE:
  - Immediate return to IDLE; outputs take their reset values; the transaction is lost.
- Identity properties (a bench checks these):
  - Encrypt then decrypt with the same count returns the original state.
  - 16/gcd(ROT,16) applications in either direction also return the original state.

Decomposition:
- Shared package boron_perm_pkg:
  - BANK_W=16.
  - FSM state enum bs_state_t {IDLE, RUN, DONE}.
  - Direction constants DIR_ENC=0, DIR_DEC=1.
- Sub-module block_shuffle_bank_rot:
  - Purely combinational, 16-bit in/out, with a dir input and ROT parameter.
  - Instantiated NBANK times in a generate loop.
- The FSM, counter and registers live in the top module.

Test Plan:
- Reset then encrypt, NBANK=4, ROT=4, in_data=64'h0123_4567_89AB_CDEF, in_iter=1:
  - out_data=64'h1230_5674_9AB8_DEFC.
  - out_valid 2 cycles after acceptance.
- Decrypt, same data, in_iter=1:
  - out_data=64'h3012_7456_B89A_FCDE.
  - out_dec=1.
- in_iter=0 with data 64'hDEAD_BEEF_CAFE_F00D:
  - out_data equals the input.
  - Latency 1 cycle.
- Encrypt, in_iter=4, ROT=4, on any data:
  - out_data equals the input (full rotation).
  - out_valid after 5 cycles.
  - busy high throughout.
- Backpressure: hold out_ready=0 for 10 cycles in DONE:
  - out_data stable.
  - in_ready=0; a new in_valid is ignored.
  - After out_ready=1, in_ready returns next cycle.
- Assert rst_n low mid-RUN, 2 cycles after acceptance of in_iter=15:
  - out_valid=0, busy=0, in_ready=1 immediately.
  - A following transaction completes correctly.
